// File: rtl/tick_target_game_pkg.sv
// rtl/tick_target_game_pkg.sv - Shared states, constants and step helpers for the tick target game
package tick_target_game_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_SHOW,
        ST_WAIT,
        ST_OVER
    } state_e;

    localparam logic [7:0] LFSR_TAPS = 8'hB8;
    localparam logic [7:0] BCD_MAX   = 8'h99;

    // Fibonacci step; the all-zero lock-up state is replaced by the seed.
    function automatic logic [7:0] lfsr_step(input logic [7:0] cur, input logic [7:0] seed);
        logic [7:0] nxt;
        nxt = {cur[6:0], ^(cur & LFSR_TAPS)};
        return (nxt == 8'h00) ? seed : nxt;
    endfunction

    function automatic logic [7:0] bcd_inc_sat(input logic [7:0] v);
        logic [7:0] r;
        if (v == BCD_MAX) begin
            r = v;
        end else if (v[3:0] == 4'd9) begin
            r = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

endpackage

// File: rtl/tick_target_game_sync_edge.sv
// rtl/tick_target_game_sync_edge.sv - Multi-flop synchronizer with rising-edge pulse output
module sync_edge #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] rise_o
);

    logic [WIDTH-1:0] sync_q [STAGES];
    logic [WIDTH-1:0] prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                sync_q[i] <= '0;
            end
            prev_q <= '0;
        end else begin
            sync_q[0] <= din_i;
            for (int i = 1; i < STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign rise_o = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/tick_target_game.sv
// rtl/tick_target_game.sv - Reaction game: pseudo-random target per tick, BCD hit score, miss limit
module tick_target_game
    import tick_target_game_pkg::*;
#(
    parameter int         NUM_LEDS    = 8,
    parameter logic [7:0] LFSR_SEED   = 8'hA5,
    parameter int         MAX_MISS    = 5,
    parameter int         SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                start,
    input  logic [NUM_LEDS-1:0] btn,
    output logic [NUM_LEDS-1:0] led,
    output logic [7:0]          score_bcd,
    output logic [3:0]          miss_cnt,
    output logic                game_over
);

    localparam int         IDX_W      = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    localparam logic [3:0] MISS_LIMIT = 4'(MAX_MISS);

    logic [NUM_LEDS-1:0] btn_rise;
    logic                start_rise;

    sync_edge #(.WIDTH(NUM_LEDS), .STAGES(SYNC_STAGES)) u_btn_sync (
        .clk   (clk),
        .rst   (rst),
        .din_i (btn),
        .rise_o(btn_rise)
    );

    sync_edge #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_start_sync (
        .clk   (clk),
        .rst   (rst),
        .din_i (start),
        .rise_o(start_rise)
    );

    state_e              state_q, state_d;
    logic [7:0]          lfsr_q, lfsr_d, lfsr_adv;
    logic [IDX_W-1:0]    target_q, target_d, idx_raw, new_target;
    logic [7:0]          score_q, score_d;
    logic [3:0]          miss_q, miss_d, miss_inc;
    logic [NUM_LEDS-1:0] led_q, led_d, tgt_bit;
    logic                over_q;

    always_comb begin
        lfsr_adv   = lfsr_step(lfsr_q, LFSR_SEED);
        idx_raw    = lfsr_adv[IDX_W-1:0];
        // Never show the same LED twice in a row.
        new_target = (idx_raw == target_q) ? idx_raw + IDX_W'(1) : idx_raw;
        tgt_bit    = NUM_LEDS'(1) << target_q;
        miss_inc   = miss_q + 4'd1;
    end

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        score_d  = score_q;
        miss_d   = miss_q;
        lfsr_d   = en ? lfsr_adv : lfsr_q;

        case (state_q)
            ST_IDLE: begin
                if (start_rise) state_d = ST_ARM;
            end
            ST_ARM, ST_WAIT: begin
                if (en) begin
                    target_d = new_target;
                    state_d  = ST_SHOW;
                end
            end
            ST_SHOW: begin
                // Button evaluation wins over a coincident tick, which is then consumed.
                if ((btn_rise & ~tgt_bit) != '0 || (btn_rise == '0 && en)) begin
                    miss_d  = miss_inc;
                    state_d = (miss_inc == MISS_LIMIT) ? ST_OVER : ST_WAIT;
                end else if (btn_rise == tgt_bit) begin
                    score_d = bcd_inc_sat(score_q);
                    state_d = ST_WAIT;
                end
            end
            ST_OVER: begin
            end
            default: state_d = ST_IDLE;
        endcase

        if (start_rise && state_q != ST_IDLE) begin
            score_d  = '0;
            miss_d   = '0;
            target_d = target_q;
            state_d  = ST_ARM;
        end
    end

    always_comb begin
        led_d = '0;
        if (state_d == ST_SHOW) begin
            led_d = NUM_LEDS'(1) << target_d;
        end else if (state_d == ST_OVER) begin
            led_d = '1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            lfsr_q   <= LFSR_SEED;
            target_q <= '0;
            score_q  <= '0;
            miss_q   <= '0;
            led_q    <= '0;
            over_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            lfsr_q   <= lfsr_d;
            target_q <= target_d;
            score_q  <= score_d;
            miss_q   <= miss_d;
            led_q    <= led_d;
            over_q   <= (state_d == ST_OVER);
        end
    end

    assign led       = led_q;
    assign score_bcd = score_q;
    assign miss_cnt  = miss_q;
    assign game_over = over_q;

endmodule

// File: tb/tb_tick_target_game.sv
// tb/tb_tick_target_game.sv - Randomized and directed self-checking bench for tick_target_game
module tb_tick_target_game;

    localparam int         NUM_LEDS    = 8;
    localparam logic [7:0] SEED        = 8'hA5;
    localparam int         MAX_MISS    = 5;
    localparam int         SYNC_STAGES = 2;
    localparam int         OW          = NUM_LEDS + 13;

    localparam int M_IDLE = 0, M_ARM = 1, M_SHOW = 2, M_WAIT = 3, M_OVER = 4;

    logic                clk = 1'b0;
    logic                rst, en, start;
    logic [NUM_LEDS-1:0] btn;
    logic [NUM_LEDS-1:0] led;
    logic [7:0]          score_bcd;
    logic [3:0]          miss_cnt;
    logic                game_over;

    int pass_cnt = 0;
    int total_cnt = 0;

    int         m_state, m_target, m_hits, m_miss;
    logic [7:0] m_lfsr;

    tick_target_game #(
        .NUM_LEDS(NUM_LEDS), .LFSR_SEED(SEED), .MAX_MISS(MAX_MISS), .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .start(start), .btn(btn),
        .led(led), .score_bcd(score_bcd), .miss_cnt(miss_cnt), .game_over(game_over)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [7:0] model_lfsr(input logic [7:0] l);
        logic [7:0] n;
        n = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
        if (n == 8'h00) n = SEED;
        return n;
    endfunction

    function automatic logic [OW-1:0] exp_vec();
        logic [NUM_LEDS-1:0] l;
        int h;
        l = '0;
        if (m_state == M_SHOW) l[m_target] = 1'b1;
        else if (m_state == M_OVER) l = '1;
        h = (m_hits > 99) ? 99 : m_hits;
        return {l, 4'(h / 10), 4'(h % 10), 4'(m_miss), (m_state == M_OVER)};
    endfunction

    task automatic model_miss();
        m_miss++;
        m_state = (m_miss == MAX_MISS) ? M_OVER : M_WAIT;
    endtask

    task automatic model_tick();
        int idx;
        m_lfsr = model_lfsr(m_lfsr);
        if (m_state == M_ARM || m_state == M_WAIT) begin
            idx = int'(m_lfsr) % NUM_LEDS;
            if (idx == m_target) idx = (idx + 1) % NUM_LEDS;
            m_target = idx;
            m_state  = M_SHOW;
        end else if (m_state == M_SHOW) begin
            model_miss();
        end
    endtask

    task automatic model_press(input logic [NUM_LEDS-1:0] mask);
        logic [NUM_LEDS-1:0] tb;
        tb = '0;
        tb[m_target] = 1'b1;
        if (m_state == M_SHOW && mask != '0) begin
            if ((mask & ~tb) != '0) model_miss();
            else begin
                m_hits++;
                m_state = M_WAIT;
            end
        end
    endtask

    // ---------------- stimulus drivers ----------------
    task automatic do_reset();
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        m_state = M_IDLE; m_lfsr = SEED; m_target = 0; m_hits = 0; m_miss = 0;
    endtask

    task automatic act_tick();
        @(negedge clk) en = 1'b1;
        @(negedge clk) en = 1'b0;
        repeat (2) @(negedge clk);
        model_tick();
    endtask

    task automatic act_press(input logic [NUM_LEDS-1:0] mask);
        @(negedge clk) btn = mask;
        repeat (6) @(negedge clk);
        btn = '0;
        repeat (4) @(negedge clk);
        model_press(mask);
    endtask

    // Raw press timed so its synchronized rise meets the tick on the same edge.
    task automatic act_press_tick(input logic [NUM_LEDS-1:0] mask);
        @(negedge clk) btn = mask;
        repeat (SYNC_STAGES) @(negedge clk);
        en = 1'b1;
        @(negedge clk) en = 1'b0;
        repeat (4) @(negedge clk);
        btn = '0;
        repeat (4) @(negedge clk);
        if (m_state == M_SHOW && mask != '0) begin
            m_lfsr = model_lfsr(m_lfsr);
            model_press(mask);
        end else begin
            model_tick();
        end
    endtask

    task automatic act_start();
        @(negedge clk) start = 1'b1;
        repeat (6) @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        if (m_state != M_IDLE) begin
            m_hits = 0;
            m_miss = 0;
        end
        m_state = M_ARM;
    endtask

    function automatic logic [NUM_LEDS-1:0] tgt_mask();
        logic [NUM_LEDS-1:0] m;
        m = '0;
        m[m_target] = 1'b1;
        return m;
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        total_cnt++;
        if ({led, score_bcd, miss_cnt, game_over} !== '0)
            $display("FAIL reset_state: got %h want 0", {led, score_bcd, miss_cnt, game_over});
        else pass_cnt++;
        act_tick();
        total_cnt++;
        if ({led, score_bcd, miss_cnt, game_over} !== exp_vec())
            $display("FAIL idle_tick: got %h want %h", {led, score_bcd, miss_cnt, game_over}, exp_vec());
        else pass_cnt++;
    endtask

    task automatic test_first_game();
        do_reset();
        act_start();
        act_tick();
        total_cnt++;
        if (led !== 8'b0000_0100)
            $display("FAIL first_target: got %b want 00000100", led);
        else pass_cnt++;
        act_tick();
        total_cnt++;
        if (miss_cnt !== 4'd1 || led !== 8'h00)
            $display("FAIL first_timeout: got miss=%0d led=%h want miss=1 led=00", miss_cnt, led);
        else pass_cnt++;
        act_tick();
        total_cnt++;
        if ({led, score_bcd, miss_cnt, game_over} !== exp_vec())
            $display("FAIL second_target: got %h want %h", {led, score_bcd, miss_cnt, game_over}, exp_vec());
        else pass_cnt++;
    endtask

    task automatic test_hit();
        act_press(tgt_mask());
        total_cnt++;
        if (score_bcd !== 8'h01 || led !== 8'h00 || miss_cnt !== 4'd1)
            $display("FAIL hit: got score=%h led=%h miss=%0d want 01 00 1", score_bcd, led, miss_cnt);
        else pass_cnt++;
        act_press(8'hFF);
        total_cnt++;
        if ({led, score_bcd, miss_cnt, game_over} !== exp_vec())
            $display("FAIL wait_ignores_btn: got %h want %h", {led, score_bcd, miss_cnt, game_over}, exp_vec());
        else pass_cnt++;
    endtask

    task automatic test_hit_with_tick();
        act_tick();
        act_press_tick(tgt_mask());
        total_cnt++;
        if (score_bcd !== 8'h02 || miss_cnt !== 4'd1 || led !== 8'h00)
            $display("FAIL hit_with_tick: got score=%h miss=%0d led=%h want 02 1 00", score_bcd, miss_cnt, led);
        else pass_cnt++;
        act_tick();
        total_cnt++;
        if ({led, score_bcd, miss_cnt, game_over} !== exp_vec())
            $display("FAIL after_hit_tick: got %h want %h", {led, score_bcd, miss_cnt, game_over}, exp_vec());
        else pass_cnt++;
    endtask

    task automatic test_multi_press();
        logic [NUM_LEDS-1:0] m;
        m = tgt_mask();
        m[(m_target + 1) % NUM_LEDS] = 1'b1;
        act_press(m);
        total_cnt++;
        if (score_bcd !== 8'h02 || miss_cnt !== 4'd2 || {led, score_bcd, miss_cnt, game_over} !== exp_vec())
            $display("FAIL multi_press: got score=%h miss=%0d want score=02 miss=2", score_bcd, miss_cnt);
        else pass_cnt++;
    endtask

    task automatic test_bcd_score();
        act_start();
        for (int i = 1; i <= 100; i++) begin
            act_tick();
            act_press(tgt_mask());
            if (i == 9 || i == 10 || i == 99 || i == 100) begin
                total_cnt++;
                if (score_bcd !== ((i == 9) ? 8'h09 : (i == 10) ? 8'h10 : 8'h99))
                    $display("FAIL bcd_hits_%0d: got %h", i, score_bcd);
                else pass_cnt++;
            end
        end
        total_cnt++;
        if ({led, score_bcd, miss_cnt, game_over} !== exp_vec())
            $display("FAIL bcd_final: got %h want %h", {led, score_bcd, miss_cnt, game_over}, exp_vec());
        else pass_cnt++;
    endtask

    task automatic test_game_over();
        act_start();
        repeat (MAX_MISS) begin
            act_tick();
            act_tick();
        end
        total_cnt++;
        if (game_over !== 1'b1 || led !== 8'hFF || miss_cnt !== 4'(MAX_MISS))
            $display("FAIL game_over: got over=%b led=%h miss=%0d want 1 ff %0d", game_over, led, miss_cnt, MAX_MISS);
        else pass_cnt++;
        act_press(8'hFF);
        act_tick();
        total_cnt++;
        if ({led, score_bcd, miss_cnt, game_over} !== exp_vec())
            $display("FAIL over_ignores: got %h want %h", {led, score_bcd, miss_cnt, game_over}, exp_vec());
        else pass_cnt++;
        act_start();
        total_cnt++;
        if ({led, score_bcd, miss_cnt, game_over} !== '0)
            $display("FAIL over_restart: got %h want 0", {led, score_bcd, miss_cnt, game_over});
        else pass_cnt++;
    endtask

    task automatic test_reset_in_show();
        act_tick();
        act_press(tgt_mask());
        act_tick();
        @(negedge clk) begin
            rst = 1'b1;
            en  = 1'b1;
            btn = tgt_mask();
        end
        @(negedge clk);
        total_cnt++;
        if ({led, score_bcd, miss_cnt, game_over} !== '0)
            $display("FAIL reset_in_show: got %h want 0", {led, score_bcd, miss_cnt, game_over});
        else pass_cnt++;
        rst = 1'b0; en = 1'b0; btn = '0;
        m_state = M_IDLE; m_lfsr = SEED; m_target = 0; m_hits = 0; m_miss = 0;
        repeat (6) @(negedge clk);
    endtask

    task automatic test_random();
        int r;
        logic [NUM_LEDS-1:0] m;
        do_reset();
        act_start();
        for (int i = 0; i < 150; i++) begin
            r = $urandom_range(0, 99);
            m = NUM_LEDS'($urandom);
            if (m_state == M_OVER && r < 50) act_start();
            else if (r < 40) act_tick();
            else if (r < 65) act_press((m_state == M_SHOW) ? tgt_mask() : (NUM_LEDS'(1) << $urandom_range(0, NUM_LEDS - 1)));
            else if (r < 82) act_press(m);
            else if (r < 95) act_press_tick((r[0]) ? tgt_mask() : m);
            else act_start();
            total_cnt++;
            if ({led, score_bcd, miss_cnt, game_over} !== exp_vec())
                $display("FAIL random_%0d: got %h want %h", i, {led, score_bcd, miss_cnt, game_over}, exp_vec());
            else pass_cnt++;
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; start = 1'b0; btn = '0;
        repeat (3) @(negedge clk);
        test_reset();
        test_first_game();
        test_hit();
        test_hit_with_tick();
        test_multi_press();
        test_bcd_score();
        test_game_over();
        test_reset_in_show();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
